// File: rtl/parameters_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parameters_pkg : shared field parameters for the Fp arithmetic layer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package parameters_pkg;

  localparam int DATA_WIDTH = 448;

  // p = 2^448 - 2^224 - 1: all ones except bit 224
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  localparam int MUL_CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_step : one MSB-first double-and-add iteration modulo p            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mul_step
  import parameters_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic                  i_bit,
  output logic [DATA_WIDTH-1:0] o_acc
);

  localparam logic [DATA_WIDTH:0] c_mod_ext = {1'b0, MODULUS};

  logic [DATA_WIDTH:0]   w_dbl;
  logic [DATA_WIDTH:0]   w_dbl_red;
  logic [DATA_WIDTH-1:0] w_t;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_sum_red;

  // Both inputs are < p, so a single subtract fully reduces each stage
  assign w_dbl     = {i_acc, 1'b0};
  assign w_dbl_red = (w_dbl >= c_mod_ext) ? (w_dbl - c_mod_ext) : w_dbl;
  assign w_t       = w_dbl_red[DATA_WIDTH-1:0];

  assign w_sum     = {1'b0, w_t} + {1'b0, i_a};
  assign w_sum_red = (w_sum >= c_mod_ext) ? (w_sum - c_mod_ext) : w_sum;

  assign o_acc = i_bit ? w_sum_red[DATA_WIDTH-1:0] : w_t;

endmodule
`default_nettype wire

// File: rtl/mod_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_mul : sequential (a*b) mod p, one multiplier bit per cycle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mod_mul
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy
);

  mul_state_t            r_state;
  mul_state_t            w_state_nxt;
  logic [MUL_CNT_W-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_done;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] w_a_red;
  logic [DATA_WIDTH-1:0] w_step;
  logic                  w_last;

  // Any 448-bit value is below 2p, so one subtract brings a into range
  assign w_a_red = (a >= MODULUS) ? (a - MODULUS) : a;
  assign w_last  = (r_cnt == '0);

  mul_step u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_bit (r_b[r_cnt]),
    .o_acc (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN && w_last) begin
      w_state_nxt = IDLE;
    end
  end

  // start takes priority in any state, which gives abort-and-restart in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_a    <= w_a_red;
      r_b    <= b;
      r_acc  <= '0;
      r_cnt  <= MUL_CNT_W'(DATA_WIDTH - 1);
      r_done <= 1'b0;
      r_busy <= 1'b1;
    end else if (r_state == RUN) begin
      r_acc <= w_step;
      if (w_last) begin
        r_result <= w_step;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        r_cnt <= r_cnt - MUL_CNT_W'(1);
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule
`default_nettype wire
